// File: rtl/assoc_pkg.sv
// Shared operation and FSM-state encodings for the associative key/data table.
package assoc_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } assoc_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_e;

endpackage

// File: rtl/assoc_match.sv
// Parallel key comparator over all valid entries plus a lowest-free-slot priority encoder.
module assoc_match #(
  parameter int KEY_W = 32,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [KEY_W-1:0]             key,
  input  logic [DEPTH-1:0][KEY_W-1:0]  keys,
  input  logic [DEPTH-1:0]             valid,
  output logic [DEPTH-1:0]             hit_vec,
  output logic                         hit,
  output logic [IDX_W-1:0]             hit_idx,
  output logic [IDX_W-1:0]             free_idx,
  output logic                         any_free
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign hit_vec[gi] = valid[gi] && (keys[gi] == key);
    end
  endgenerate

  assign hit      = |hit_vec;
  assign any_free = ~&valid;

  // hit_vec is at most one-hot, so OR-ing the indices yields the hit position.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_vec[i]) hit_idx = hit_idx | IDX_W'(i);
    end
  end

  // Scan high to low so the lowest free index is the last one assigned.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/assoc_table.sv
// Fixed-capacity key->data table with valid/ready requests, registered responses
// and a multi-cycle CLEAR sequencer.
module assoc_table
  import assoc_pkg::*;
#(
  parameter int KEY_W  = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [KEY_W-1:0]  req_key,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0][KEY_W-1:0] key_mem;
  logic [DATA_W-1:0]           data_mem [DEPTH];

  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg, empty_reg;
  state_e           state_reg, state_next;
  logic [IDX_W-1:0] clr_idx_reg, clr_idx_next;

  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_hit_reg, rsp_hit_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rd_sel;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;

  logic [DEPTH-1:0]  hit_vec;
  logic              m_hit;
  logic [IDX_W-1:0]  hit_idx, free_idx;
  logic              any_free;

  logic      accept;
  assoc_op_e op;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign op        = assoc_op_e'(req_op);

  assoc_match #(.KEY_W(KEY_W), .DEPTH(DEPTH)) u_match (
    .key      (req_key),
    .keys     (key_mem),
    .valid    (valid_reg),
    .hit_vec  (hit_vec),
    .hit      (m_hit),
    .hit_idx  (hit_idx),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  always_comb begin
    state_next     = state_reg;
    clr_idx_next   = clr_idx_reg;
    valid_next     = valid_reg;
    count_next     = count_reg;
    rsp_valid_next = 1'b0;
    rsp_hit_next   = 1'b0;
    rsp_err_next   = 1'b0;
    rd_sel         = 1'b0;
    wr_en          = 1'b0;
    wr_idx         = hit_idx;

    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_READ: begin
              rsp_valid_next = 1'b1;
              rsp_hit_next   = m_hit;
              rd_sel         = m_hit;
            end
            OP_WRITE: begin
              rsp_valid_next = 1'b1;
              if (m_hit) begin
                rsp_hit_next = 1'b1;
                wr_en        = 1'b1;
              end else if (any_free) begin
                wr_en                = 1'b1;
                wr_idx               = free_idx;
                valid_next[free_idx] = 1'b1;
                count_next           = count_reg + CNT_W'(1);
              end else begin
                rsp_err_next = 1'b1;
              end
            end
            OP_DELETE: begin
              rsp_valid_next = 1'b1;
              rsp_hit_next   = m_hit;
              valid_next     = valid_reg & ~hit_vec;
              if (m_hit) count_next = count_reg - CNT_W'(1);
            end
            OP_CLEAR: begin
              // Entry 0 is dropped on the accept edge so the whole sweep fits DEPTH cycles.
              valid_next[0] = 1'b0;
              state_next    = ST_CLEARING;
              clr_idx_next  = IDX_W'(1);
            end
            default: ;
          endcase
        end
      end
      ST_CLEARING: begin
        valid_next[clr_idx_reg] = 1'b0;
        if (clr_idx_reg == IDX_W'(DEPTH - 1)) begin
          state_next     = ST_IDLE;
          clr_idx_next   = '0;
          count_next     = '0;
          rsp_valid_next = 1'b1;
        end else begin
          clr_idx_next = clr_idx_reg + IDX_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      clr_idx_reg   <= '0;
      valid_reg     <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_hit_reg   <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      clr_idx_reg   <= clr_idx_next;
      valid_reg     <= valid_next;
      count_reg     <= count_next;
      full_reg      <= (count_next == CNT_W'(DEPTH));
      empty_reg     <= (count_next == '0);
      rsp_valid_reg <= rsp_valid_next;
      rsp_hit_reg   <= rsp_hit_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_data_reg  <= rd_sel ? data_mem[hit_idx] : '0;
    end
  end

  // Entry payload carries no reset; validity alone decides whether it is visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_idx]  <= req_key;
      data_mem[wr_idx] <= req_data;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_hit   = rsp_hit_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = rsp_data_reg;
  assign count     = count_reg;
  assign full      = full_reg;
  assign empty     = empty_reg;

endmodule

// File: tb/tb_assoc_table.sv
// Directed bench for assoc_table: reset, read/write/delete, capacity limits,
// back-to-back ordering and the CLEAR sequence including reset during CLEAR.
module tb_assoc_table;

  localparam int KEY_W  = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [KEY_W-1:0]  req_key;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid, rsp_hit, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [CNT_W-1:0]  count;
  logic              full, empty;

  int vectors = 0;
  int errors  = 0;

  logic              o_valid, o_hit, o_err;
  logic [DATA_W-1:0] o_data;

  always #5 clk = ~clk;

  assoc_table #(.KEY_W(KEY_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_key   (req_key),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Drives one request for a single accept edge, then captures the response at the next negedge.
  task automatic issue(input logic [1:0] op, input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_data  = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_key   = 'x;
    req_data  = 'x;
    @(negedge clk);
    o_valid = rsp_valid;
    o_hit   = rsp_hit;
    o_err   = rsp_err;
    o_data  = rsp_data;
    $display("op=%0d key=%h data=%h -> valid=%b hit=%b err=%b rdata=%h count=%0d", op, key, data, o_valid, o_hit, o_err, o_data, count);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_key   = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({req_ready, rsp_valid, rsp_hit, rsp_err, full, empty} !== 6'b100001 || count !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b rv=%b hit=%b err=%b full=%b empty=%b count=%0d, want 1 0 0 0 0 1 0", req_ready, rsp_valid, rsp_hit, rsp_err, full, empty, count);
    end
    issue(2'd0, 32'h10, 32'h0);
    vectors++;
    if (o_valid !== 1'b1 || o_hit !== 1'b0 || o_data !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL read_empty: valid=%b hit=%b data=%h empty=%b, want 1 0 0 1", o_valid, o_hit, o_data, empty);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_pulse: rsp_valid=%b one cycle later, want 0", rsp_valid);
    end
  endtask

  task automatic test_write_read();
    issue(2'd1, 32'h10, 32'hAA);
    vectors++;
    if (o_valid !== 1'b1 || o_hit !== 1'b0 || o_err !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL write_new: valid=%b hit=%b err=%b count=%0d empty=%b, want 1 0 0 1 0", o_valid, o_hit, o_err, count, empty);
    end
    issue(2'd1, 32'h20, 32'hBB);
    issue(2'd0, 32'h10, 32'h0);
    vectors++;
    if (o_hit !== 1'b1 || o_data !== 32'hAA || count !== 5'd2) begin
      errors++;
      $display("FAIL read_hit: hit=%b data=%h count=%0d, want 1 aa 2", o_hit, o_data, count);
    end
    issue(2'd1, 32'h10, 32'hCC);
    vectors++;
    if (o_hit !== 1'b1 || o_err !== 1'b0 || count !== 5'd2) begin
      errors++;
      $display("FAIL overwrite: hit=%b err=%b count=%0d, want 1 0 2", o_hit, o_err, count);
    end
    issue(2'd0, 32'h10, 32'h0);
    vectors++;
    if (o_data !== 32'hCC) begin
      errors++;
      $display("FAIL overwrite_read: data=%h, want cc", o_data);
    end
  endtask

  // Entries 0/1 hold 0x10/0x20; keys 0x100+i fill indices 2..15.
  task automatic test_fill();
    for (int i = 2; i < DEPTH; i++) issue(2'd1, 32'h100 + i, 32'h1000 + i);
    vectors++;
    if (full !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d, want 1 16", full, count);
    end
    issue(2'd1, 32'h99, 32'h5A);
    vectors++;
    if (o_err !== 1'b1 || o_hit !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL write_full: err=%b hit=%b count=%0d, want 1 0 16", o_err, o_hit, count);
    end
    issue(2'd0, 32'h99, 32'h0);
    vectors++;
    if (o_hit !== 1'b0 || o_data !== '0) begin
      errors++;
      $display("FAIL rejected_absent: hit=%b data=%h, want 0 0", o_hit, o_data);
    end
    issue(2'd1, 32'h20, 32'h77);
    vectors++;
    if (o_hit !== 1'b1 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL write_full_hit: hit=%b err=%b, want 1 0", o_hit, o_err);
    end
  endtask

  task automatic test_delete();
    issue(2'd2, 32'h103, 32'h0);
    vectors++;
    if (o_hit !== 1'b1 || count !== 5'd15 || full !== 1'b0) begin
      errors++;
      $display("FAIL delete_hit: hit=%b count=%0d full=%b, want 1 15 0", o_hit, count, full);
    end
    issue(2'd0, 32'h103, 32'h0);
    vectors++;
    if (o_hit !== 1'b0) begin
      errors++;
      $display("FAIL deleted_read: hit=%b, want 0", o_hit);
    end
    issue(2'd1, 32'h300, 32'h33);
    issue(2'd0, 32'h300, 32'h0);
    vectors++;
    if (o_hit !== 1'b1 || o_data !== 32'h33 || full !== 1'b1) begin
      errors++;
      $display("FAIL refill_slot: hit=%b data=%h full=%b, want 1 33 1", o_hit, o_data, full);
    end
    // Neighbour entries must be untouched by the reuse of slot 3.
    issue(2'd0, 32'h104, 32'h0);
    vectors++;
    if (o_hit !== 1'b1 || o_data !== 32'h1004) begin
      errors++;
      $display("FAIL neighbour_read: hit=%b data=%h, want 1 1004", o_hit, o_data);
    end
    issue(2'd2, 32'h555, 32'h0);
    vectors++;
    if (o_hit !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL delete_miss: hit=%b count=%0d, want 0 16", o_hit, count);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'd2, 32'h104, 32'h0);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_key   = 32'h5;
    req_data  = 32'h7;
    @(posedge clk);
    #1;
    req_op   = 2'd0;
    req_key  = 32'h5;
    req_data = 'x;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_write: valid=%b hit=%b ready=%b, want 1 0 1", rsp_valid, rsp_hit, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    $display("b2b read key=5 -> valid=%b hit=%b rdata=%h count=%0d", rsp_valid, rsp_hit, rsp_data, count);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_data !== 32'h7 || count !== 5'd16) begin
      errors++;
      $display("FAIL b2b_read: valid=%b hit=%b data=%h count=%0d, want 1 1 7 16", rsp_valid, rsp_hit, rsp_data, count);
    end
  endtask

  task automatic test_clear();
    int low_cycles = 0;
    int early_rsp  = 0;
    req_valid = 1'b1;
    req_op    = 2'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 0; c < DEPTH - 1; c++) begin
      @(negedge clk);
      if (req_ready === 1'b0) low_cycles++;
      if (rsp_valid !== 1'b0) early_rsp++;
    end
    vectors++;
    if (low_cycles != DEPTH - 1 || early_rsp != 0) begin
      errors++;
      $display("FAIL clear_busy: ready low %0d cycles early_rsp=%0d, want 15 0", low_cycles, early_rsp);
    end
    @(negedge clk);
    $display("clear done -> valid=%b hit=%b err=%b ready=%b count=%0d", rsp_valid, rsp_hit, rsp_err, req_ready, count);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1 || count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: valid=%b hit=%b err=%b ready=%b count=%0d empty=%b full=%b, want 1 0 0 1 0 1 0", rsp_valid, rsp_hit, rsp_err, req_ready, count, empty, full);
    end
    issue(2'd0, 32'h10, 32'h0);
    vectors++;
    if (o_hit !== 1'b0 || o_data !== '0) begin
      errors++;
      $display("FAIL clear_read: hit=%b data=%h, want 0 0", o_hit, o_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    int stray_rsp = 0;
    for (int i = 0; i < 4; i++) issue(2'd1, 32'h40 + i, 32'h400 + i);
    req_valid = 1'b1;
    req_op    = 2'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (empty !== 1'b1 || req_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL async_reset: empty=%b ready=%b count=%0d, want 1 1 0", empty, req_ready, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < DEPTH + 2; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray_rsp++;
    end
    vectors++;
    if (stray_rsp != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_clear: stray_rsp=%0d empty=%b, want 0 1", stray_rsp, empty);
    end
    issue(2'd0, 32'h41, 32'h0);
    vectors++;
    if (o_valid !== 1'b1 || o_hit !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_read: valid=%b hit=%b, want 1 0", o_valid, o_hit);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_delete();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
